// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_kbd_rx_sync_filter.sv
// Pin synchroniser plus a run-length glitch filter on ps2_clk.
// Emits a one-cycle fall_pulse when the filtered clock goes low.
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall_pulse
);

    localparam int             FW       = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0]  RUN_LAST = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_s;
    logic                   clk_filt;
    logic [FW-1:0]          run_cnt;

    assign clk_s     = clk_sr[SYNC_STAGES-1];
    assign data_sync = data_sr[SYNC_STAGES-1];

    // The filtered level only follows the synchronised clock after it has
    // disagreed for FILTER_LEN consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sr     <= '1;
            data_sr    <= '1;
            clk_filt   <= 1'b1;
            run_cnt    <= '0;
            fall_pulse <= 1'b0;
        end else begin
            clk_sr     <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            data_sr    <= {data_sr[SYNC_STAGES-2:0], ps2_data};
            fall_pulse <= 1'b0;
            if (clk_s == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
                clk_filt   <= clk_s;
                run_cnt    <= '0;
                fall_pulse <= ~clk_s;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame FSM with parity/start/stop/timeout checks,
// E0/F0 prefix decoding and a first-word fall-through event FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 15000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_brk,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            make_cnt,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        overflow
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    LAST_IDX   = 4'(PS2_FRAME_BITS - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    logic       data_s;
    logic       fall;

    ps2_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_sync (data_s),
        .fall_pulse(fall)
    );

    ps2_state_e                   state, state_nxt;
    logic [3:0]                   bit_idx;
    logic [PS2_FRAME_BITS-1:0]    shreg;
    logic [TW-1:0]                timer;
    logic                         timeout;
    logic                         frame_bad, par_bad, byte_good, push_req;
    logic                         ext_flag, brk_flag;
    logic [7:0]                   rx_byte;
    logic                         full, pop, do_push;
    logic [AW-1:0]                wr_ptr, rd_ptr;
    ps2_evt_t                     mem [FIFO_DEPTH];
    ps2_evt_t                     head;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            IDLE:  if (fall) state_nxt = RECV;
            RECV: begin
                if (fall) begin
                    if (bit_idx == LAST_IDX) state_nxt = CHECK;
                end else if (timer == TIMER_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            timer   <= '0;
        end else begin
            if (fall && state == IDLE)      bit_idx <= 4'd1;
            else if (fall && state == RECV) bit_idx <= bit_idx + 4'd1;
            if (state == RECV && !fall) timer <= timer + 1'b1;
            else                        timer <= '0;
        end
    end

    // Frame bits arrive LSB first, so after eleven shifts shreg[0] is the start bit.
    always_ff @(posedge clk) begin
        if (fall && state != CHECK) shreg <= {data_s, shreg[PS2_FRAME_BITS-1:1]};
    end

    assign rx_byte   = shreg[8:1];
    assign frame_bad = shreg[0] | ~shreg[10];
    assign par_bad   = ~(^shreg[9:1]);
    assign byte_good = (state == CHECK) && !frame_bad && !par_bad;
    assign push_req  = byte_good && (rx_byte != PS2_PFX_EXT) && (rx_byte != PS2_PFX_BRK);

    assign evt_valid = (fifo_level != '0);
    assign full      = (fifo_level == LEVEL_FULL);
    assign pop       = evt_valid && evt_ready;
    assign do_push   = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
            overflow   <= 1'b0;
            make_cnt   <= '0;
        end else begin
            err_frame  <= timeout || (state == CHECK && frame_bad);
            err_parity <= (state == CHECK) && !frame_bad && par_bad;
            overflow   <= push_req && !do_push;
            if (timeout || (state == CHECK && !byte_good)) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_good) begin
                if (rx_byte == PS2_PFX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_PFX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
            if (do_push && !brk_flag) make_cnt <= make_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{ext: ext_flag, brk: brk_flag, code: rx_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign evt_code = evt_valid ? head.code : 8'h00;
    assign evt_ext  = evt_valid & head.ext;
    assign evt_brk  = evt_valid & head.brk;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed scenarios plus randomized frames, checked
// against a queue-based event model.
module tb_ps2_kbd_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rdy_val = 1'b1;
    logic       rdy_rand = 1'b0;
    logic       rnd_bit = 1'b1;
    logic       evt_ready;
    logic       evt_valid, evt_ext, evt_brk;
    logic [7:0] evt_code;
    logic [3:0] fifo_level;
    logic [7:0] make_cnt;
    logic       err_parity, err_frame, overflow;

    assign evt_ready = rdy_rand ? rnd_bit : rdy_val;

    ps2_kbd_rx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO),
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_brk   (evt_brk),
        .fifo_level(fifo_level),
        .make_cnt  (make_cnt),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] mq[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] m_make = 8'd0;
    int         exp_par = 0, exp_frm = 0, exp_ovf = 0;
    int         n_par = 0, n_frm = 0, n_ovf = 0;
    logic [9:0] last_pop = 10'd0;
    logic [9:0] got;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Event model: what a correct receiver makes of one complete frame.
    task automatic model_byte(input logic [7:0] b, input int fault);
        if (fault == 1) begin
            exp_par++;
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (fault != 0) begin
            exp_frm++;
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (mq.size() < DEPTH) begin
                mq.push_back({m_ext, m_brk, b});
                if (!m_brk) m_make++;
            end else begin
                exp_ovf++;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    // fault: 0 none, 1 parity flipped, 2 start=1, 3 stop=0
    task automatic send_frame(input logic [7:0] b, input int fault, input int period, input int nbits);
        logic [10:0] bits;
        int q;
        q         = period / 4;
        bits[0]   = (fault == 2);
        bits[8:1] = b;
        bits[9]   = ~(^b) ^ (fault == 1);
        bits[10]  = (fault != 3);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(q);
            if (i == 10) model_byte(b, fault);
            ps2_clk = 1'b0;
            cyc(2 * q);
            ps2_clk = 1'b1;
            cyc(q);
        end
        ps2_data = 1'b1;
    endtask

    task automatic quiet(input string tag);
        cyc(40);
        chk({tag, "_level"}, int'(fifo_level), mq.size());
        chk({tag, "_make"},  int'(make_cnt),   int'(m_make));
        chk({tag, "_perr"},  n_par, exp_par);
        chk({tag, "_ferr"},  n_frm, exp_frm);
        chk({tag, "_ovf"},   n_ovf, exp_ovf);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(evt_valid),  0);
        chk({tag, "_level"}, int'(fifo_level), 0);
        chk({tag, "_make"},  int'(make_cnt),   0);
        chk({tag, "_code"},  int'(evt_code),   0);
        chk({tag, "_pulses"}, int'({err_parity, err_frame, overflow}), 0);
    endtask

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #2 rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every accepted head must be the model's next event.
    initial begin
        forever begin
            @(negedge clk);
            if (err_parity) n_par++;
            if (err_frame)  n_frm++;
            if (overflow)   n_ovf++;
            if (!rst && evt_valid && evt_ready) begin
                got = {evt_ext, evt_brk, evt_code};
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no event", got);
                end else begin
                    chk("pop_event", int'(got), int'(mq.pop_front()));
                end
                last_pop = got;
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] ovf_codes [9];
        int r, fault;
        ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        cyc(4);
        chk_zero("rst_hold");
        rst = 1'b0;
        cyc(2);
        chk_zero("rst_rel");

        send_frame(8'h1C, 0, 200, 11);
        quiet("t1");
        chk("t1_code_lit", int'(last_pop), 10'h01C);
        chk("t1_make_lit", int'(make_cnt), 1);

        send_frame(8'hE0, 0, 200, 11);
        send_frame(8'hF0, 0, 200, 11);
        send_frame(8'h74, 0, 200, 11);
        quiet("t2");
        chk("t2_code_lit", int'(last_pop), 10'h374);
        chk("t2_make_lit", int'(make_cnt), 1);

        send_frame(8'h1C, 1, 200, 11);
        send_frame(8'h32, 0, 200, 11);
        quiet("t3a");
        chk("t3_perr_lit", n_par, 1);
        chk("t3_code_lit", int'(last_pop), 10'h032);
        send_frame(8'h1C, 3, 200, 11);
        quiet("t3b");
        chk("t3_ferr_lit", n_frm, 1);

        send_frame(8'hAA, 0, 200, 6);
        cyc(1100);
        exp_frm++;
        m_ext = 1'b0; m_brk = 1'b0;
        quiet("t4a");
        chk("t4_ferr_lit", n_frm, 2);
        send_frame(8'h15, 0, 200, 11);
        quiet("t4b");
        chk("t4_code_lit", int'(last_pop), 10'h015);

        repeat (5) begin
            ps2_clk = 1'b0;
            cyc(2);
            ps2_clk = 1'b1;
            cyc(20);
        end
        quiet("glitch");

        send_frame(8'h55, 0, 200, 5);
        rst = 1'b1;
        cyc(2);
        chk_zero("rst_mid");
        mq.delete();
        m_make = 8'd0;
        m_ext = 1'b0; m_brk = 1'b0;
        rst = 1'b0;
        cyc(10);

        rdy_val = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send_frame(ovf_codes[i], 0, 80, 11);
        quiet("ovf");
        chk("ovf_level_lit", int'(fifo_level), 8);
        chk("ovf_pulse_lit", n_ovf, 1);
        chk("ovf_make_lit", int'(make_cnt), 8);
        rdy_val = 1'b1;
        cyc(20);
        quiet("drain");
        chk("drain_last_lit", int'(last_pop), 10'h03E);

        rdy_rand = 1'b1;
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 99);
            fault = (r < 8) ? 1 : (r < 14) ? 2 : (r < 20) ? 3 : 0;
            r = $urandom_range(0, 9);
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
            send_frame(b, fault, 60, 11);
            quiet("rnd");
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        cyc(20);
        quiet("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver. It replaces the single-register scan-code latch with a filtered, parity-checked, timeout-protected frame receiver and an E0/F0 prefix decoder. Decoded key events go into a FIFO with a valid/ready handshake. It sits between the board PS/2 pins and consumers such as seven-segment display drivers and the keyboard-to-ASCII stage.

Parameters:
FIFO_DEPTH, 8, number of event entries buffered; power of two, >= 2
TIMEOUT_CYC, 15000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned
SYNC_STAGES, 2, flip-flop synchroniser depth on ps2_clk and ps2_data; >= 2
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered ps2_clk changes level
CNT_W, 8, width of the key-make counter

Ports:
clk  in  1  system clock; the only clock in the block
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head when evt_valid is high
evt_code  out  8  scan code of head event
evt_ext  out  1  head event was preceded by E0
evt_brk  out  1  head event was preceded by F0 (key release)
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held
make_cnt  out  CNT_W  count of make events successfully pushed; wraps modulo 2^CNT_W
err_parity  out  1  one-cycle pulse on a frame with bad odd parity
err_frame  out  1  one-cycle pulse on bad start/stop bit or timeout
overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. All outputs go to 0: evt_valid=0, fifo_level=0, make_cnt=0, all pulses 0. FSM goes to IDLE and the prefix flags clear. Synchroniser and filter registers reset to 1 (idle bus). A partial frame in progress at reset is discarded.
- Edge detection: the falling edge is taken on the filtered ps2_clk after SYNC_STAGES synchronisation plus FILTER_LEN filtering. A glitch shorter than FILTER_LEN cycles produces no edge. ps2_data is sampled from its synchroniser output on the cycle the falling edge is detected.
- FSM states IDLE, RECV, CHECK:
  - IDLE: on a falling edge, sample the start bit, set bit_idx=1 and go to RECV.
  - RECV: on each falling edge, shift in a bit and increment bit_idx. When bit_idx reaches 11, go to CHECK.
  - RECV timeout: the timer clears on every edge. If it reaches TIMEOUT_CYC, pulse err_frame, discard the frame and go to IDLE.
  - CHECK: lasts one cycle, then returns to IDLE. Frame layout is start(0), d0..d7 LSB first, odd parity, stop(1).
    - start!=0 or stop!=1: pulse err_frame, discard the frame.
    - Otherwise, parity wrong (XOR of d[7:0] and the parity bit must equal 1): pulse err_parity, discard the frame.
    - Otherwise the byte is good.
- Prefix decoding applies to good bytes:
  - 8'hE0 sets ext_flag.
  - 8'hF0 sets brk_flag.
  - Any other byte pushes {ext_flag, brk_flag, byte} and clears both flags in the same cycle.
  - A discarded frame clears both flags.
- Push timing: latency from the last (stop-bit) falling edge detection to the push is 1 cycle (the CHECK cycle). evt_valid is high on the following cycle if the FIFO was empty.
- FIFO: synchronous, first-word fall-through. The head is visible on evt_* whenever evt_valid=1.
  - A pop occurs when evt_valid && evt_ready.
  - Push to a full FIFO with no pop in that cycle: the event is dropped, overflow pulses, make_cnt is unchanged.
  - Push and pop in the same cycle while full: both occur and the level is unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- make_cnt increments on every successful push with brk=0.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum (IDLE/RECV/CHECK);
  - constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_FRAME_BITS=11;
  - the event struct {ext, brk, code[7:0]}.
- One sub-module: ps2_sync_filter (SYNC_STAGES, FILTER_LEN). It synchronises both pins, filters the clock, and outputs the filtered data plus a one-cycle fall_pulse.
- The FIFO stays inline.

Test Plan:
- Send the frame for 8'h1C (parity 0) at a 200-cycle bit period with TIMEOUT_CYC=1000, evt_ready=1 → one event: code=1C, ext=0, brk=0; make_cnt=1; no error pulses.
- Send the sequence E0,F0,74 → exactly one event: code=74, ext=1, brk=1; make_cnt unchanged; no events for the prefix bytes.
- Send 8'h1C with the parity bit inverted, then a valid 8'h32 → err_parity pulses once, then one event code=32 is output. Repeat with stop=0 → err_frame pulses.
- Send 6 bits of a frame, then hold ps2_clk high for 1000 cycles → err_frame pulses at timeout. The next full frame 8'h15 decodes correctly.
- With evt_ready=0, send FIFO_DEPTH+1 make codes → fifo_level=8 and overflow pulses once. Then assert evt_ready → the first 8 codes drain in order; make_cnt=8.
- Inject 2-cycle low glitches on ps2_clk during IDLE → no edge detected, no events. Assert rst mid-frame → outputs return to 0 and the next frame decodes correctly.
